// File: rtl/spi_flash_slave_if.sv
// Pin bundle between an SPI flash master and the spi_flash_slave serial-flash model.
// With SPI_SLAVE_WP_EN defined the bundle also carries the active-low write-protect pin wp_n.
interface spi_flash_slave_if;
  logic       spi_clk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       wip;
  logic       wel;
  logic       cmd_strobe;
  logic [7:0] last_cmd;
`ifdef SPI_SLAVE_WP_EN
  logic       wp_n;

  modport master (output spi_clk, spi_cs_n, spi_mosi, wp_n,
                  input  spi_miso, wip, wel, cmd_strobe, last_cmd);
  modport slave  (input  spi_clk, spi_cs_n, spi_mosi, wp_n,
                  output spi_miso, wip, wel, cmd_strobe, last_cmd);
`else
  modport master (output spi_clk, spi_cs_n, spi_mosi,
                  input  spi_miso, wip, wel, cmd_strobe, last_cmd);
  modport slave  (input  spi_clk, spi_cs_n, spi_mosi,
                  output spi_miso, wip, wel, cmd_strobe, last_cmd);
`endif
endinterface

// File: rtl/spi_flash_slave.sv
// SPI mode-0 serial-flash responder, fully oversampled in the clk domain.
// Optional write protection (wp_n pin, status bit7) is built when SPI_SLAVE_WP_EN is defined.
module spi_flash_slave #(
  parameter int          MEM_AW      = 8,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter logic [7:0]  DEV_ID      = 8'h17,
  parameter int          PROG_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  spi_flash_slave_if.slave bus
);
  localparam int DEPTH    = 1 << MEM_AW;
  localparam int BUSY_MAX = (PROG_CYCLES > DEPTH) ? PROG_CYCLES : DEPTH;
  localparam int CW       = $clog2(BUSY_MAX + 1);
  localparam int PW       = (MEM_AW < 8) ? MEM_AW : 8;
  localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'((32'd1 << PW) - 32'd1);

  localparam logic [7:0] CMD_PP    = 8'h02;
  localparam logic [7:0] CMD_NORD  = 8'h03;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_RDID  = 8'hAB;
  localparam logic [7:0] CMD_JDID  = 8'h9F;
  localparam logic [7:0] CMD_ERASE = 8'hD7;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_IGNORE} state_e;

  function automatic logic [7:0] jedec_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    jedec_byte = JEDEC_ID[23:16];
      2'd1:    jedec_byte = JEDEC_ID[15:8];
      default: jedec_byte = JEDEC_ID[7:0];
    endcase
  endfunction

  logic [2:0]        sclk_q, cs_q;
  logic [1:0]        mosi_q;
  state_e            state_q, state_d;
  logic [2:0]        bit_q, bit_d, byte_q, byte_d;
  logic [6:0]        shift_q, shift_d;
  logic [MEM_AW-1:0] addr_q, addr_d, ptr_q, ptr_d, eptr_q, eptr_d;
  logic [7:0]        tx_q, tx_d, cmd_q, cmd_d;
  logic [1:0]        id_q, id_d;
  logic [CW-1:0]     busy_q, busy_d;
  logic              miso_q, miso_d, strobe_q, strobe_d, cmd_ok_q, cmd_ok_d;
  logic              wip_q, wip_d, wel_q, wel_d, erase_q, erase_d;
  logic [7:0]        mem [DEPTH];

  logic              mem_we_s;
  logic [MEM_AW-1:0] mem_wa_s, new_addr_s, ptr_inc_s;
  logic [7:0]        mem_wd_s, rx_byte_s, status_s;
  logic              sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s, mosi_s, wp_s;

`ifdef SPI_SLAVE_WP_EN
  logic [1:0] wp_q;
  // Write-protect pin synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wp_q <= 2'b11;
    else     wp_q <= {wp_q[0], bus.wp_n};
  end
  assign wp_s = ~wp_q[1];
`else
  assign wp_s = 1'b0;
`endif

  assign sclk_rise_s = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_s = ~sclk_q[1] & sclk_q[2];
  assign cs_rise_s   = cs_q[1] & ~cs_q[2];
  assign cs_fall_s   = ~cs_q[1] & cs_q[2];
  assign mosi_s      = mosi_q[1];
  assign rx_byte_s   = {shift_q, mosi_s};
  assign new_addr_s  = MEM_AW'({addr_q, mosi_s});
  assign status_s    = {wp_s, 5'b00000, wel_q, wip_q};
  // Programming wraps inside the current 256-byte page (or the whole array when smaller).
  assign ptr_inc_s   = (ptr_q & ~PAGE_MASK) | ((ptr_q + MEM_AW'(1)) & PAGE_MASK);

  // Next-state logic: busy timer, transaction FSM, commit on deselect.
  always_comb begin
    state_d = state_q;  bit_d = bit_q;    byte_d = byte_q;   shift_d = shift_q;
    addr_d = addr_q;    ptr_d = ptr_q;    tx_d = tx_q;       miso_d = miso_q;
    cmd_d = cmd_q;      strobe_d = 1'b0;  cmd_ok_d = cmd_ok_q; id_d = id_q;
    wip_d = wip_q;      wel_d = wel_q;    erase_d = erase_q; busy_d = busy_q;
    eptr_d = eptr_q;    mem_we_s = 1'b0;  mem_wa_s = ptr_q;  mem_wd_s = rx_byte_s;

    if (wip_q) begin
      if (erase_q) begin
        mem_we_s = 1'b1;
        mem_wa_s = eptr_q;
        mem_wd_s = 8'hFF;
        eptr_d   = eptr_q + MEM_AW'(1);
      end else begin
        eptr_d = eptr_q;
      end
      if (busy_q == CW'(1)) begin
        wip_d = 1'b0; wel_d = 1'b0; erase_d = 1'b0; busy_d = '0;
      end else begin
        busy_d = busy_q - CW'(1);
      end
    end else begin
      busy_d = busy_q;
    end

    if (cs_rise_s) begin
      state_d = S_IDLE; miso_d = 1'b0; tx_d = 8'h00; cmd_ok_d = 1'b0;
      if (cmd_ok_q && state_q != S_IDLE) begin
        case (cmd_q)
          CMD_WREN:  if (byte_q == 3'd1 && bit_q == 3'd0) wel_d = 1'b1;
                     else wel_d = wel_q;
          CMD_PP:    if (wel_q && !wp_s && byte_q >= 3'd5) begin
                       wip_d = 1'b1; busy_d = CW'(PROG_CYCLES);
                     end else begin
                       wip_d = wip_q;
                     end
          CMD_ERASE: if (wel_q && !wp_s && byte_q == 3'd4 && bit_q == 3'd0) begin
                       wip_d = 1'b1; erase_d = 1'b1; busy_d = CW'(DEPTH); eptr_d = '0;
                     end else begin
                       wip_d = wip_q;
                     end
          default:   wip_d = wip_q;
        endcase
      end else begin
        wel_d = wel_d;
      end
    end else if (cs_fall_s) begin
      state_d = S_CMD; bit_d = 3'd0; byte_d = 3'd0; tx_d = 8'h00; miso_d = 1'b0; cmd_ok_d = 1'b0;
    end else if (state_q != S_IDLE) begin
      if (sclk_fall_s) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end else if (sclk_rise_s) begin
        shift_d = rx_byte_s[6:0];
        bit_d   = bit_q + 3'd1;
        addr_d  = (state_q == S_ADDR) ? new_addr_s : addr_q;
        if (bit_q == 3'd7) begin
          byte_d = (byte_q == 3'd7) ? 3'd7 : byte_q + 3'd1;
          case (state_q)
            S_CMD: begin
              cmd_d = rx_byte_s; strobe_d = 1'b1; cmd_ok_d = 1'b1; state_d = S_IGNORE; tx_d = 8'h00;
              if (wip_q && rx_byte_s != CMD_RDSR) begin
                cmd_ok_d = 1'b0;
              end else begin
                case (rx_byte_s)
                  CMD_RDSR:                   begin state_d = S_RDATA; tx_d = status_s; end
                  CMD_RDID:                   begin state_d = S_RDATA; tx_d = DEV_ID; end
                  CMD_JDID:                   begin state_d = S_RDATA; tx_d = jedec_byte(2'd0); id_d = 2'd1; end
                  CMD_PP, CMD_NORD, CMD_ERASE: state_d = S_ADDR;
                  default:                    state_d = S_IGNORE;
                endcase
              end
            end
            S_ADDR: begin
              if (byte_q == 3'd3) begin
                ptr_d = new_addr_s;
                case (cmd_q)
                  CMD_PP:   state_d = S_WDATA;
                  CMD_NORD: begin
                    state_d = S_RDATA; tx_d = mem[new_addr_s]; ptr_d = new_addr_s + MEM_AW'(1);
                  end
                  default:  state_d = S_IGNORE;
                endcase
              end else begin
                ptr_d = ptr_q;
              end
            end
            S_WDATA: begin
              mem_we_s = wel_q & ~wp_s;
              ptr_d    = ptr_inc_s;
            end
            S_RDATA: begin
              case (cmd_q)
                CMD_RDSR: tx_d = status_s;
                CMD_RDID: tx_d = DEV_ID;
                CMD_JDID: begin tx_d = jedec_byte(id_q); id_d = (id_q == 2'd2) ? 2'd0 : id_q + 2'd1; end
                CMD_NORD: begin tx_d = mem[ptr_q]; ptr_d = ptr_q + MEM_AW'(1); end
                default:  tx_d = 8'h00;
              endcase
            end
            default: tx_d = 8'h00;
          endcase
        end else begin
          byte_d = byte_q;
        end
      end else begin
        tx_d = tx_q;
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  // Synchronizers and all control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= 3'b000; cs_q <= 3'b111; mosi_q <= 2'b00;
      state_q <= S_IDLE; bit_q <= 3'd0; byte_q <= 3'd0; shift_q <= 7'd0;
      addr_q <= '0; ptr_q <= '0; eptr_q <= '0; tx_q <= 8'h00; cmd_q <= 8'h00;
      id_q <= 2'd0; busy_q <= '0; miso_q <= 1'b0; strobe_q <= 1'b0; cmd_ok_q <= 1'b0;
      wip_q <= 1'b0; wel_q <= 1'b0; erase_q <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.spi_clk};
      cs_q   <= {cs_q[1:0], bus.spi_cs_n};
      mosi_q <= {mosi_q[0], bus.spi_mosi};
      state_q <= state_d; bit_q <= bit_d; byte_q <= byte_d; shift_q <= shift_d;
      addr_q <= addr_d; ptr_q <= ptr_d; eptr_q <= eptr_d; tx_q <= tx_d; cmd_q <= cmd_d;
      id_q <= id_d; busy_q <= busy_d; miso_q <= miso_d; strobe_q <= strobe_d; cmd_ok_q <= cmd_ok_d;
      wip_q <= wip_d; wel_q <= wel_d; erase_q <= erase_d;
    end
  end

  // Byte array, single write port shared by page program and erase sweep; not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) mem[mem_wa_s] <= mem_wd_s;
  end

  assign bus.spi_miso   = miso_q;
  assign bus.wip        = wip_q;
  assign bus.wel        = wel_q;
  assign bus.cmd_strobe = strobe_q;
  assign bus.last_cmd   = cmd_q;
endmodule

// File: tb/tb_spi_flash_slave.sv
// Directed bench for spi_flash_slave: drives SPI mode-0 transactions and checks responses and status.
module tb_spi_flash_slave;
  localparam int HALF = 4;
  localparam int PROG = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   strobe_cnt = 0;

  spi_flash_slave_if bus();

  spi_flash_slave #(.MEM_AW(8), .JEDEC_ID(24'hEF4018), .DEV_ID(8'h17), .PROG_CYCLES(PROG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.cmd_strobe) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      bus.spi_mosi = tx[i];
      tick(HALF);
      rx[i] = bus.spi_miso;
      bus.spi_clk = 1'b1;
      tick(HALF);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_begin();
    bus.spi_cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_end();
    tick(HALF);
    bus.spi_cs_n = 1'b1;
    tick(6);
  endtask

  task automatic send_cmd_addr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] rx;
    spi_byte(cmd, rx);
    spi_byte(addr[23:16], rx);
    spi_byte(addr[15:8], rx);
    spi_byte(addr[7:0], rx);
  endtask

  task automatic wren();
    logic [7:0] rx;
    cs_begin();
    spi_byte(8'h06, rx);
    cs_end();
  endtask

  task automatic rdsr(output logic [7:0] st);
    logic [7:0] rx;
    cs_begin();
    spi_byte(8'h05, rx);
    spi_byte(8'h00, st);
    cs_end();
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (bus.wip === 1'b1 && t < 5000) begin
      tick(1);
      t++;
    end
    check(tag, {31'd0, bus.wip}, 32'd0);
  endtask

  initial begin
    logic [7:0] rx;
    int         s0;
    int         n;
    bus.spi_clk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
`ifdef SPI_SLAVE_WP_EN
    bus.wp_n = 1'b1;
`endif
    tick(3);
    check("rst_miso", {31'd0, bus.spi_miso}, 32'd0);
    check("rst_wip", {31'd0, bus.wip}, 32'd0);
    check("rst_wel", {31'd0, bus.wel}, 32'd0);
    check("rst_strobe", {31'd0, bus.cmd_strobe}, 32'd0);
    check("rst_last_cmd", {24'd0, bus.last_cmd}, 32'd0);
    rst = 1'b0;
    tick(4);

    // JEDEC ID, then wrap back to the first byte
    s0 = strobe_cnt;
    cs_begin();
    spi_byte(8'h9F, rx);
    spi_byte(8'h00, rx); check("jdid_b0", {24'd0, rx}, 32'hEF);
    spi_byte(8'h00, rx); check("jdid_b1", {24'd0, rx}, 32'h40);
    spi_byte(8'h00, rx); check("jdid_b2", {24'd0, rx}, 32'h18);
    spi_byte(8'h00, rx); check("jdid_wrap", {24'd0, rx}, 32'hEF);
    cs_end();
    check("jdid_strobes", strobe_cnt - s0, 32'd1);
    check("jdid_last_cmd", {24'd0, bus.last_cmd}, 32'h9F);

    cs_begin();
    spi_byte(8'hAB, rx);
    spi_byte(8'h00, rx); check("rdid_b0", {24'd0, rx}, 32'h17);
    spi_byte(8'h00, rx); check("rdid_b1", {24'd0, rx}, 32'h17);
    cs_end();

    cs_begin();
    spi_byte(8'h5A, rx);
    spi_byte(8'h00, rx); check("unknown_miso", {24'd0, rx}, 32'h00);
    cs_end();

    wren();
    rdsr(rx); check("wren_status", {24'd0, rx}, 32'h02);

    // Page program A5,5A at 0x10, poll busy, read back
    cs_begin();
    send_cmd_addr(8'h02, 24'h000010);
    spi_byte(8'hA5, rx);
    spi_byte(8'h5A, rx);
    cs_end();
    check("pp_wip_set", {31'd0, bus.wip}, 32'd1);
    rdsr(rx); check("pp_busy_status", {24'd0, rx}, 32'h03);
    wait_idle("pp_busy_end");
    rdsr(rx); check("pp_done_status", {24'd0, rx}, 32'h00);
    cs_begin();
    send_cmd_addr(8'h03, 24'h000010);
    spi_byte(8'h00, rx); check("nord_10", {24'd0, rx}, 32'hA5);
    spi_byte(8'h00, rx); check("nord_11", {24'd0, rx}, 32'h5A);
    cs_end();

    // Page wrap at 0xFE, with busy duration measured from the CS release
    wren();
    cs_begin();
    send_cmd_addr(8'h02, 24'h0000FE);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    spi_byte(8'h33, rx);
    tick(HALF);
    bus.spi_cs_n = 1'b1;
    n = 0;
    while (bus.wip !== 1'b1 && n < 20) begin tick(1); n++; end
    n = 0;
    while (bus.wip === 1'b1 && n < 5000) begin tick(1); n++; end
    check("pp_busy_cycles", n, PROG);
    cs_begin();
    send_cmd_addr(8'h03, 24'h0000FE);
    spi_byte(8'h00, rx); check("wrap_fe", {24'd0, rx}, 32'h11);
    spi_byte(8'h00, rx); check("wrap_ff", {24'd0, rx}, 32'h22);
    cs_end();
    cs_begin();
    send_cmd_addr(8'h03, 24'h000000);
    spi_byte(8'h00, rx); check("wrap_00", {24'd0, rx}, 32'h33);
    cs_end();

    // Program without WREN must not touch the array
    cs_begin();
    send_cmd_addr(8'h02, 24'h000010);
    spi_byte(8'h77, rx);
    cs_end();
    check("pp_nowel_wip", {31'd0, bus.wip}, 32'd0);
    cs_begin();
    send_cmd_addr(8'h03, 24'h000010);
    spi_byte(8'h00, rx); check("pp_nowel_data", {24'd0, rx}, 32'hA5);
    cs_end();

    // Erase; reads are ignored while busy
    wren();
    cs_begin();
    send_cmd_addr(8'hD7, 24'h000000);
    cs_end();
    check("erase_wip_set", {31'd0, bus.wip}, 32'd1);
    cs_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx); check("erase_busy_miso", {24'd0, rx}, 32'h00);
    cs_end();
    check("erase_still_busy", {31'd0, bus.wip}, 32'd1);
    wait_idle("erase_end");
    check("erase_wel_clr", {31'd0, bus.wel}, 32'd0);
    cs_begin();
    send_cmd_addr(8'h03, 24'h000000);
    for (int a = 0; a < 256; a++) begin
      spi_byte(8'h00, rx);
      check($sformatf("erase_ff_%0d", a), {24'd0, rx}, 32'hFF);
    end
    cs_end();

    // WREN truncated after 5 bits
    cs_begin();
    spi_bits(8'h06, 5, rx);
    cs_end();
    check("wren_short", {31'd0, bus.wel}, 32'd0);

    // Reset during program busy
    wren();
    cs_begin();
    send_cmd_addr(8'h02, 24'h000030);
    spi_byte(8'h44, rx);
    cs_end();
    check("rstpp_wip", {31'd0, bus.wip}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstpp_wip_clr", {31'd0, bus.wip}, 32'd0);
    check("rstpp_wel_clr", {31'd0, bus.wel}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
